// File: rtl/opl3_host_port.sv
// rtl/opl3_host_port.sv - OPL3 host register port: queue forwarding, timer snoop, status/IRQ
//
// Forwards every host write into the sequencer queue as a one-cycle {addr, data}
// push. Snoops bank-0 timer registers 0x02/0x03/0x04 to run the OPL T1/T2 timers
// locally and returns the OPL status byte with IRQ.
//
// Optional feature macro: OPL3_HOST_TIMERS_EN (timers, snoop decode, status).
// Without it, dout/irq are constant 0 and only forwarding and q_ovf exist.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   cs, we, a, din  host access strobe, write enable, {bank, data_port}, write data
//   dout, irq       registered status byte; irq = dout[7]
//   q_addr, q_data  queue entry captured from the host write
//   q_wr            one-cycle queue push strobe
//   q_full          queue full; writes seen while set are dropped
//   q_ovf           sticky dropped-write indicator

module opl3_host_port #(
  parameter int CLK_HZ = 32000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic [1:0] q_addr,
  output logic [7:0] q_data,
  output logic       q_wr,
  input  logic       q_full,
  output logic       q_ovf
);

  logic       host_wr;
  logic       wr_q, wr_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       ovf_q, ovf_d;

  assign host_wr = cs & we;

  // Capture register: the push is driven straight from these flops, so a push
  // captured just before reset still appears during the reset cycle.
  always_comb begin
    wr_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    if (host_wr) begin
      if (q_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_d   = 1'b1;
        addr_d = a;
        data_d = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= 1'b0;
      addr_q <= 2'd0;
      data_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q_wr   = wr_q;
  assign q_addr = addr_q;
  assign q_data = data_q;
  assign q_ovf  = ovf_q;

`ifdef OPL3_HOST_TIMERS_EN
  localparam int TICK = CLK_HZ / 12500;
  localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    pre_q, pre_d;
  logic [7:0]    idx0_q, idx0_d, idx1_q, idx1_d;
  logic [7:0]    preset1_q, preset1_d, preset2_q, preset2_d;
  logic [7:0]    cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic          run1_q, run1_d, run2_q, run2_d;
  logic          mask1_q, mask1_d, mask2_q, mask2_d;
  logic          flag1_q, flag1_d, flag2_q, flag2_d;
  logic [7:0]    dout_q, dout_d;

  logic       t80, t320;
  logic [7:0] sel_idx;
  logic       addr_wr, data_wr, ctrl_wr, flag_clr;
  logic       load1, load2, set1, set2;

  assign t80  = (tick_q == '0);
  // t320 fires on every 4th t80, the one that wraps the prescaler.
  assign t320 = t80 && (pre_q == 2'd3);

  // Index of the addressed bank; data writes to bank 1 are masked out below,
  // so only idx0 can ever match a timer register.
  assign sel_idx  = a[1] ? idx1_q : idx0_q;
  assign addr_wr  = host_wr && !a[0];
  assign data_wr  = host_wr && a[0] && !a[1];
  assign ctrl_wr  = data_wr && (sel_idx == 8'h04) && !din[7];
  assign flag_clr = data_wr && (sel_idx == 8'h04) && din[7];

  assign load1 = ctrl_wr && din[0];
  assign load2 = ctrl_wr && din[1];

  // A load coinciding with a tick discards that tick, including its overflow.
  assign set1 = run1_q && t80  && (cnt1_q == 8'hFF) && !mask1_q && !load1;
  assign set2 = run2_q && t320 && (cnt2_q == 8'hFF) && !mask2_q && !load2;

  always_comb begin
    tick_d    = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
    pre_d     = t80 ? pre_q + 2'd1 : pre_q;
    idx0_d    = idx0_q;
    idx1_d    = idx1_q;
    preset1_d = preset1_q;
    preset2_d = preset2_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    run1_d    = run1_q;
    run2_d    = run2_q;
    mask1_d   = mask1_q;
    mask2_d   = mask2_q;

    if (addr_wr) begin
      if (a[1]) idx1_d = din;
      else      idx0_d = din;
    end

    if (data_wr && sel_idx == 8'h02) preset1_d = din;
    if (data_wr && sel_idx == 8'h03) preset2_d = din;

    if (ctrl_wr) begin
      mask1_d = din[6];
      mask2_d = din[5];
      run1_d  = din[0];
      run2_d  = din[1];
    end

    // Reloads use the preset held before this cycle, so a preset write while
    // running only matters at the next overflow.
    if (load1) begin
      cnt1_d = preset1_q;
    end else if (run1_q && t80) begin
      cnt1_d = (cnt1_q == 8'hFF) ? preset1_q : cnt1_q + 8'd1;
    end

    if (load2) begin
      cnt2_d = preset2_q;
    end else if (run2_q && t320) begin
      cnt2_d = (cnt2_q == 8'hFF) ? preset2_q : cnt2_q + 8'd1;
    end

    // Set beats clear when both land on the same edge.
    flag1_d = (flag1_q && !flag_clr) || set1;
    flag2_d = (flag2_q && !flag_clr) || set2;
    dout_d  = {flag1_d | flag2_d, flag1_d, flag2_d, 5'b00000};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= '0;
      pre_q     <= 2'd0;
      idx0_q    <= 8'h00;
      idx1_q    <= 8'h00;
      preset1_q <= 8'h00;
      preset2_q <= 8'h00;
      cnt1_q    <= 8'h00;
      cnt2_q    <= 8'h00;
      run1_q    <= 1'b0;
      run2_q    <= 1'b0;
      mask1_q   <= 1'b0;
      mask2_q   <= 1'b0;
      flag1_q   <= 1'b0;
      flag2_q   <= 1'b0;
      dout_q    <= 8'h00;
    end else begin
      tick_q    <= tick_d;
      pre_q     <= pre_d;
      idx0_q    <= idx0_d;
      idx1_q    <= idx1_d;
      preset1_q <= preset1_d;
      preset2_q <= preset2_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      run1_q    <= run1_d;
      run2_q    <= run2_d;
      mask1_q   <= mask1_d;
      mask2_q   <= mask2_d;
      flag1_q   <= flag1_d;
      flag2_q   <= flag2_d;
      dout_q    <= dout_d;
    end
  end

  assign dout = dout_q;
  assign irq  = dout_q[7];
`else
  assign dout = 8'h00;
  assign irq  = 1'b0;
`endif

endmodule
